// File: rtl/arr_accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arr_accum_pkg
//  Description : Shared types and helpers for the multi-channel array
//                accumulator: FSM state encoding, mode constants and the
//                saturate/truncate helper used by every lane.
//  Ports       : (package, no ports)
//  Revision    : 1.0 - initial release
// ============================================================================
package arr_accum_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } state_t;

   localparam logic MODE_COH  = 1'b0;   // signed coherent sum
   localparam logic MODE_NCOH = 1'b1;   // sum of magnitudes

   // Working width for lane arithmetic; wide enough for any legal OUT_WIDTH+1.
   localparam int c_WORK_W = 64;

   typedef struct packed {
      logic                        ovf;
      logic signed [c_WORK_W-1:0]  value;
   } sat_res_t;

   // Clamp a wide sum to the signed out_w range when sat_en is set. With
   // sat_en clear the value passes through and the caller keeps the low
   // out_w bits, which gives two's-complement wrap.
   function automatic sat_res_t sat_trunc(input logic signed [c_WORK_W-1:0] value,
                                          input int                          out_w,
                                          input bit                          sat_en);
      sat_res_t                   r;
      logic signed [c_WORK_W-1:0] v_max;
      logic signed [c_WORK_W-1:0] v_min;
      v_max   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      v_min   = -v_max - 64'sd1;
      r.ovf   = 1'b0;
      r.value = value;
      if (sat_en) begin
         if (value > v_max) begin
            r.value = v_max;
            r.ovf   = 1'b1;
         end else if (value < v_min) begin
            r.value = v_min;
            r.ovf   = 1'b1;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arr_accum_mc_lane.sv
`default_nettype none
// ============================================================================
//  Module      : arr_accum_lane
//  Description : One channel of the accumulator datapath (combinational):
//                term selection (signed / magnitude), add to stored partial
//                sum, saturate or wrap to OUT_WIDTH.
//  Ports       : i_x     - input sample (signed, IN_WIDTH)
//                i_mode  - 0 coherent, 1 non-coherent
//                i_first - pass 0: ignore stored value (overwrite)
//                i_acc   - stored partial sum (signed, OUT_WIDTH)
//                o_sum   - new partial sum (signed, OUT_WIDTH)
//                o_ovf   - this lane clamped
//  Revision    : 1.0 - initial release
// ============================================================================
module arr_accum_lane
   import arr_accum_pkg::*;
#(
   parameter int IN_WIDTH  = 12,
   parameter int OUT_WIDTH = 21,
   parameter int SAT_EN    = 1
) (
   input  logic signed [IN_WIDTH-1:0]  i_x,
   input  logic                        i_mode,
   input  logic                        i_first,
   input  logic signed [OUT_WIDTH-1:0] i_acc,
   output logic signed [OUT_WIDTH-1:0] o_sum,
   output logic                        o_ovf
);

   logic signed [c_WORK_W-1:0] w_x64;
   logic signed [c_WORK_W-1:0] w_acc64;
   logic signed [c_WORK_W-1:0] w_term;
   logic signed [c_WORK_W-1:0] w_sum;
   sat_res_t                   w_res;
   logic                       w_unused;

   // Extend before negating so |-2^(IN_WIDTH-1)| is represented exactly.
   assign w_x64   = c_WORK_W'(i_x);
   assign w_acc64 = c_WORK_W'(i_acc);
   assign w_term  = ((i_mode == MODE_NCOH) && (w_x64 < 0)) ? -w_x64 : w_x64;
   assign w_sum   = i_first ? w_term : (w_acc64 + w_term);
   assign w_res   = sat_trunc(w_sum, OUT_WIDTH, SAT_EN != 0);
   assign o_sum   = w_res.value[OUT_WIDTH-1:0];
   assign o_ovf   = w_res.ovf;
   assign w_unused = ^w_res.value[c_WORK_W-1:OUT_WIDTH];

endmodule
`default_nettype wire

// File: rtl/arr_accum_mc.sv
`default_nettype none
// ============================================================================
//  Module      : arr_accum_mc
//  Description : Multi-channel array accumulator. Sums N_ARGS-bin arrays over
//                a runtime number of passes for N_CH channels, coherent or
//                non-coherent, with optional saturation and sticky overflow.
//  Ports       : clk, resetn (sync, active low)
//                start   - latch mode/acc_len and (re)start accumulation
//                mode    - 0 coherent, 1 non-coherent
//                acc_len - pass count (0 treated as 1)
//                R_in/we - next bin for all channels
//                R_out/valid/last - final-pass results, one per bin
//                busy    - accumulation in progress
//                ovf     - sticky clamp flag since last start
//  Revision    : 1.0 - initial release
// ============================================================================
module arr_accum_mc
   import arr_accum_pkg::*;
#(
   parameter int IN_WIDTH  = 12,
   parameter int OUT_WIDTH = 21,
   parameter int N_ARGS    = 64,
   parameter int N_CH      = 2,
   parameter int CNT_WIDTH = 8,
   parameter int SAT_EN    = 1
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic                        mode,
   input  logic [CNT_WIDTH-1:0]        acc_len,
   input  logic [N_CH*IN_WIDTH-1:0]    R_in,
   input  logic                        we,
   output logic [N_CH*OUT_WIDTH-1:0]   R_out,
   output logic                        valid,
   output logic                        last,
   output logic                        busy,
   output logic                        ovf
);

   localparam int BIN_W = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
   localparam logic [BIN_W-1:0] c_bin_last = BIN_W'(N_ARGS - 1);

   if ((OUT_WIDTH < IN_WIDTH + 1) || (OUT_WIDTH > c_WORK_W - 1)) begin : g_bad_width
      $error("arr_accum_mc: OUT_WIDTH must be in [IN_WIDTH+1, 63]");
   end

   state_t                      r_state;
   state_t                      w_state_nxt;
   logic                        r_mode;
   logic [CNT_WIDTH-1:0]        r_len;
   logic [CNT_WIDTH-1:0]        r_pass;
   logic [BIN_W-1:0]            r_bin;
   logic [N_CH*OUT_WIDTH-1:0]   r_mem [0:N_ARGS-1];
   logic [N_CH*OUT_WIDTH-1:0]   r_out;
   logic                        r_valid;
   logic                        r_last;
   logic                        r_ovf;

   logic [N_CH*OUT_WIDTH-1:0]   w_rd;
   logic [N_CH*OUT_WIDTH-1:0]   w_sum;
   logic [N_CH-1:0]             w_lane_ovf;
   logic                        w_proc;
   logic                        w_first;
   logic                        w_final;
   logic                        w_bin_last;

   // A we coinciding with start belongs to no run and is dropped.
   assign w_proc     = (r_state == ST_ACCUM) && we && !start;
   assign w_first    = (r_pass == '0);
   assign w_final    = (r_pass == (r_len - 1'b1));
   assign w_bin_last = (r_bin == c_bin_last);

   // Asynchronous read: bin advances on every we, so the location being
   // written is never the one read next cycle (N_ARGS >= 2).
   assign w_rd = r_mem[r_bin];

   for (genvar c = 0; c < N_CH; c++) begin : g_lane
      arr_accum_lane #(
         .IN_WIDTH  (IN_WIDTH),
         .OUT_WIDTH (OUT_WIDTH),
         .SAT_EN    (SAT_EN)
      ) u_lane (
         .i_x     (R_in[c*IN_WIDTH +: IN_WIDTH]),
         .i_mode  (r_mode),
         .i_first (w_first),
         .i_acc   (w_rd[c*OUT_WIDTH +: OUT_WIDTH]),
         .o_sum   (w_sum[c*OUT_WIDTH +: OUT_WIDTH]),
         .o_ovf   (w_lane_ovf[c])
      );
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = ST_ACCUM;
      end else if (w_proc && w_final && w_bin_last) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // ---------------- counters, control, outputs ----------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_mode  <= MODE_COH;
         r_len   <= '0;
         r_pass  <= '0;
         r_bin   <= '0;
         r_out   <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         if (start) begin
            r_mode <= mode;
            r_len  <= (acc_len == '0) ? CNT_WIDTH'(1) : acc_len;
            r_pass <= '0;
            r_bin  <= '0;
            r_ovf  <= 1'b0;
         end else if (w_proc) begin
            r_ovf <= r_ovf | (|w_lane_ovf);
            if (w_bin_last) begin
               r_bin  <= '0;
               r_pass <= r_pass + 1'b1;
            end else begin
               r_bin <= r_bin + 1'b1;
            end
            if (w_final) begin
               r_out   <= w_sum;
               r_valid <= 1'b1;
               r_last  <= w_bin_last;
            end
         end
      end
   end

   // Partial-sum RAM; final-pass results bypass it.
   always_ff @(posedge clk) begin
      if (w_proc && !w_final) begin
         r_mem[r_bin] <= w_sum;
      end
   end

   assign R_out = r_out;
   assign valid = r_valid;
   assign last  = r_last;
   assign busy  = (r_state == ST_ACCUM);
   assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_arr_accum_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arr_accum_mc
//  Description : Self-checking bench for arr_accum_mc with a scoreboard of
//                expected final-pass results, plus two narrow instances
//                (OUT_WIDTH=14) for saturate and wrap behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arr_accum_mc;

   localparam int IW = 12;
   localparam int OW = 21;
   localparam int NA = 64;
   localparam int SW = 14;

   logic            clk;
   logic            resetn;
   logic            start;
   logic            mode;
   logic [7:0]      acc_len;
   logic [2*IW-1:0] R_in;
   logic            we;
   logic [2*OW-1:0] R_out;
   logic            valid, last, busy, ovf;
   logic [2*SW-1:0] R_out_s, R_out_w;
   logic            valid_s, last_s, busy_s, ovf_s;
   logic            valid_w, last_w, busy_w, ovf_w;

   arr_accum_mc #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .N_ARGS(NA), .N_CH(2),
                  .CNT_WIDTH(8), .SAT_EN(1)) dut (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode), .acc_len(acc_len),
      .R_in(R_in), .we(we), .R_out(R_out), .valid(valid), .last(last),
      .busy(busy), .ovf(ovf));

   arr_accum_mc #(.IN_WIDTH(IW), .OUT_WIDTH(SW), .N_ARGS(NA), .N_CH(2),
                  .CNT_WIDTH(8), .SAT_EN(1)) dut_sat (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode), .acc_len(acc_len),
      .R_in(R_in), .we(we), .R_out(R_out_s), .valid(valid_s), .last(last_s),
      .busy(busy_s), .ovf(ovf_s));

   arr_accum_mc #(.IN_WIDTH(IW), .OUT_WIDTH(SW), .N_ARGS(NA), .N_CH(2),
                  .CNT_WIDTH(8), .SAT_EN(0)) dut_wrap (
      .clk(clk), .resetn(resetn), .start(start), .mode(mode), .acc_len(acc_len),
      .R_in(R_in), .we(we), .R_out(R_out_w), .valid(valid_w), .last(last_w),
      .busy(busy_w), .ovf(ovf_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint e0;
      longint e1;
      logic   lst;
      int     cyc;
   } exp_t;

   exp_t   sb[$];
   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   int     n_valid  = 0;
   int     n_sat    = 0;
   int     n_wrap   = 0;
   bit     aux_en   = 1'b0;
   longint acc0 [NA];
   longint acc1 [NA];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Scoreboard consumer for the main instance.
   always @(negedge clk) begin
      exp_t e;
      if (valid === 1'b1) begin
         n_valid++;
         chk("sb_nonempty", longint'(sb.size() > 0), 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ch0", $signed(R_out[0 +: OW]), e.e0);
            chk("ch1", $signed(R_out[OW +: OW]), e.e1);
            chk("last", last, e.lst);
            chk("latency", cyc, e.cyc);
            if (last === 1'b1) chk("busy_at_last", busy, 0);
         end
      end
   end

   // Narrow instances, checked only during the saturation test.
   always @(negedge clk) begin
      if (aux_en && valid_s === 1'b1) begin
         n_sat++;
         chk("sat_ch0", $signed(R_out_s[0 +: SW]), 8191);
         chk("sat_ch1", $signed(R_out_s[SW +: SW]), 8191);
         chk("sat_ovf", ovf_s, 1);
      end
      if (aux_en && valid_w === 1'b1) begin
         n_wrap++;
         chk("wrap_ch0", $signed(R_out_w[0 +: SW]), -6149);
         chk("wrap_ovf", ovf_w, 0);
      end
   end

   function automatic longint term(input logic m, input longint x);
      return (m && x < 0) ? -x : x;
   endfunction

   // Drive one accumulation. n_stop>0 aborts after that many we (no outputs
   // expected); start_we puts a we in the start cycle that must be ignored.
   task automatic run(input logic m, input int len, input int x0, input int x1,
                      input int duty, input bit rnd, input bit start_we, input int n_stop);
      int     eff, total, done, bin, pass, v0, v1;
      exp_t   e;
      eff   = (len == 0) ? 1 : len;
      total = (n_stop > 0) ? n_stop : eff * NA;
      done  = 0;
      @(posedge clk); #1;
      start   = 1'b1;
      mode    = m;
      acc_len = len[7:0];
      R_in    = {x1[IW-1:0], x0[IW-1:0]};
      we      = start_we;
      @(posedge clk); #1;
      start = 1'b0;
      we    = 1'b0;
      chk("busy_run", busy, 1);
      while (done < total) begin
         if (int'($urandom_range(0, 99)) < duty) begin
            v0 = rnd ? int'($urandom_range(0, 4095)) - 2048 : x0;
            v1 = rnd ? int'($urandom_range(0, 4095)) - 2048 : x1;
            we   = 1'b1;
            R_in = {v1[IW-1:0], v0[IW-1:0]};
            bin  = done % NA;
            pass = done / NA;
            if (pass == 0) begin
               acc0[bin] = term(m, v0);
               acc1[bin] = term(m, v1);
            end else begin
               acc0[bin] += term(m, v0);
               acc1[bin] += term(m, v1);
            end
            if (n_stop == 0 && pass == eff - 1) begin
               e.e0  = acc0[bin];
               e.e1  = acc1[bin];
               e.lst = (bin == NA - 1);
               e.cyc = cyc + 1;
               sb.push_back(e);
            end
            done++;
         end else begin
            we = 1'b0;
         end
         @(posedge clk); #1;
      end
      we = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      chk(tag, sb.size(), 0);
   endtask

   initial begin
      int nv;
      resetn = 1'b0; start = 1'b0; mode = 1'b0; acc_len = '0; R_in = '0; we = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_rout", R_out, 0);
      resetn = 1'b1;

      // 1: coherent, 20 passes, full rate
      n_valid = 0;
      run(1'b0, 20, 1, -1, 100, 1'b0, 1'b0, 0);
      drain("t1_drain");
      chk("t1_count", n_valid, 64);
      chk("t1_busy", busy, 0);
      chk("t1_ovf", ovf, 0);

      // 2: non-coherent then coherent with extreme negative input
      run(1'b1, 5, -3, -2048, 100, 1'b0, 1'b0, 0);
      drain("t2n_drain");
      run(1'b0, 5, -3, -2048, 100, 1'b0, 1'b0, 0);
      drain("t2c_drain");

      // 3: narrow saturate / wrap instances
      aux_en = 1'b1; n_sat = 0; n_wrap = 0;
      run(1'b0, 5, 2047, 2047, 100, 1'b0, 1'b0, 0);
      drain("t3_drain");
      aux_en = 1'b0;
      chk("t3_sat_count", n_sat, 64);
      chk("t3_wrap_count", n_wrap, 64);
      chk("t3_main_ovf", ovf, 0);

      // 4: same as 1 with 30% we duty; latency checked per output
      n_valid = 0;
      run(1'b0, 20, 1, -1, 30, 1'b0, 1'b0, 0);
      drain("t4_drain");
      chk("t4_count", n_valid, 64);

      // random data, non-coherent, several passes with gaps
      run(1'b1, 3, 0, 0, 60, 1'b1, 1'b0, 0);
      drain("trnd_n_drain");
      run(1'b0, 4, 0, 0, 80, 1'b1, 1'b0, 0);
      drain("trnd_c_drain");

      // 5a: abort mid-pass 3, then a short run
      run(1'b0, 20, 3, 3, 100, 1'b0, 1'b0, 3 * NA + 10);
      n_valid = 0;
      run(1'b0, 2, 7, 7, 100, 1'b0, 1'b0, 0);
      drain("t5a_drain");
      chk("t5a_count", n_valid, 64);

      // 5b: reset mid-run, then we without start must give nothing
      run(1'b0, 3, 5, 5, 100, 1'b0, 1'b0, 100);
      resetn = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t5b_valid", valid, 0);
      chk("t5b_busy", busy, 0);
      chk("t5b_ovf", ovf, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      nv = n_valid;
      we = 1'b1;
      repeat (150) @(posedge clk);
      #1 we = 1'b0;
      @(negedge clk);
      chk("t5b_no_output", n_valid, nv);
      chk("t5b_busy_after", busy, 0);

      // 6: acc_len=0 -> single pass; we in start cycle ignored
      n_valid = 0;
      run(1'b0, 0, -5, 9, 100, 1'b0, 1'b1, 0);
      drain("t6_drain");
      chk("t6_count", n_valid, 64);
      chk("t6_busy", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arr_accum_mc.md
Name: arr_accum_mc

Overview:
Multi-channel array accumulator for the acquisition engine. It sums N_ARGS-bin correlation arrays over a runtime-set number of passes, for N_CH channels in parallel. It generalises the single-channel coherent/non-coherent accumulator:
- runtime mode select (coherent signed sum or non-coherent magnitude sum)
- runtime pass count
- start/abort control, optional saturation with a sticky overflow flag

Instances chain: valid of one instance drives we of the next.

Parameters:
IN_WIDTH, 12, signed input sample width per channel
OUT_WIDTH, 21, signed accumulator/output width per channel; OUT_WIDTH < IN_WIDTH+1 is illegal (elaboration error)
N_ARGS, 64, bins per array (per pass)
N_CH, 2, parallel channels
CNT_WIDTH, 8, width of acc_len
SAT_EN, 1, 1 = saturate to signed OUT_WIDTH limits; 0 = two's-complement wrap

Ports:
clk  in  1  core clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle pulse: latch mode/acc_len, begin new accumulation (aborts any run in progress)
mode  in  1  0 = coherent signed sum, 1 = non-coherent sum of |x|
acc_len  in  CNT_WIDTH  number of passes; 0 is treated as 1
R_in  in  N_CH*IN_WIDTH  channel c at bits [c*IN_WIDTH +: IN_WIDTH], signed
we  in  1  R_in carries the next bin
R_out  out  N_CH*OUT_WIDTH  accumulated result, same packing as R_in
valid  out  1  R_out valid (one cycle per bin, final pass only)
last  out  1  with valid: bin N_ARGS-1
busy  out  1  accumulation in progress
ovf  out  1  sticky: some lane saturated since last start (always 0 when SAT_EN=0)

Behaviour:
- Reset (resetn=0 at clk edge): state IDLE; R_out=0, valid=0, last=0, busy=0, ovf=0, bin and pass counters=0. Memory contents are don't-care.
- States:
  - IDLE: we ignored. start -> ACCUM; latch mode and max(acc_len,1); clear counters and ovf; busy=1 from the next cycle.
  - ACCUM: each we processes bin = bin_cnt for all channels.
    - bin_cnt wraps N_ARGS-1 -> 0 and increments pass_cnt.
    - At bin N_ARGS-1 of the final pass -> IDLE; busy=0 in the cycle valid/last are asserted.
- start during ACCUM: immediate restart with newly latched values; no valid for the aborted run; ovf cleared.
- A we in the same cycle as start is ignored.
- Datapath per lane:
  - term = sign-extended x (mode 0) or |x| (mode 1). |-2^(IN_WIDTH-1)| = 2^(IN_WIDTH-1) exactly, so extend before negating.
  - Pass 0: mem[bin] <= term (overwrite, no clear cycle needed).
  - Pass p>0: mem[bin] <= mem[bin] + term.
  - Final pass: the same sum drives R_out, and memory need not be written.
- Latency: valid asserted exactly 1 cycle after the final-pass we; R_out is registered.
- Gaps in we are allowed; outputs track we one-for-one.
- Saturation (SAT_EN=1): compute the sum at OUT_WIDTH+1 bits; clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; ovf <= 1 on any clamp. SAT_EN=0: truncate to OUT_WIDTH.
- Memory is one RAM of N_ARGS words x N_CH*OUT_WIDTH, read-modify-write.
  - Read is asynchronous or address-forwarded, so back-to-back we on consecutive bins is full rate.
  - Hazard-free because bin advances every we and N_ARGS >= 2.
- Reset mid-operation: returns to IDLE; no valid until a new start.

Decomposition:
- Package arr_accum_pkg: state enum (ST_IDLE, ST_ACCUM), mode constants (MODE_COH=0, MODE_NCOH=1), function sat_trunc(value, SAT_EN) returning clamped value plus overflow bit.
- Sub-module arr_accum_lane: per-channel combinational term/abs, add, saturate. Generated N_CH times.
- Top module owns the FSM, counters, RAM, and output registers.

Test Plan:
1. Coherent, acc_len=20, we every cycle, ch0=+1, ch1=-1:
   - exactly 64 valid pulses, ch0=20, ch1=-20
   - last on the 64th pulse; busy=0 afterwards; ovf=0
2. Non-coherent, acc_len=5:
   - ch0=-3 -> 15; ch1=-2048 -> 10240
   - repeat with mode=0 -> -15 / -10240
3. OUT_WIDTH=14, input 2047, acc_len=5:
   - SAT_EN=1 -> 8191 with ovf=1
   - SAT_EN=0 -> -6149 with ovf=0
4. Random we at 30% duty, same stimulus as test 1:
   - identical results
   - each valid exactly 1 cycle after a final-pass we; none during passes 0..18
5. Abort and reset:
   - start mid-pass 3, then run acc_len=2 with input 7 -> all outputs 14, no stale data
   - resetn=0 mid-run -> valid/busy/ovf=0; no output until next start
6. acc_len=0, input ch0=-5, ch1=9:
   - outputs -5/9 emitted during the first pass
   - start+we in the same cycle -> that we is not counted (64 further we required)
